// File: rtl/ps2_pkg.sv
// Shared types and field offsets for the PS/2 mouse receiver.
// Imported by the byte receiver, the packet assembler and the bench.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_st_e;

  localparam int PS2M_TOGGLE = 24;
  localparam int PS2M_DY     = 16;
  localparam int PS2M_DX     = 8;
  localparam int PS2M_STAT   = 0;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 line inputs and decoded mouse word outputs.
// master drives the bus lines, slave is the receiver.
interface ps2_mouse_rx_if;
  import ps2_pkg::*;

  logic        ps2_clk_i;
  logic        ps2_data_i;
  logic [24:0] ps2_mouse;
  logic        rx_err;

  modport master (
    output ps2_clk_i,
    output ps2_data_i,
    input  ps2_mouse,
    input  rx_err
  );

  modport slave (
    input  ps2_clk_i,
    input  ps2_data_i,
    output ps2_mouse,
    output rx_err
  );

endinterface

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchroniser, glitch filter, frame FSM
// and the shared frame/packet idle timeout.
module ps2_rx_byte
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       pkt_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       frame_to
);

  localparam int CW = 4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fclk_q, fclk_d;
  logic          fdat_q, fdat_d;
  logic [CW-1:0] fclk_cnt_q, fclk_cnt_d;
  logic [CW-1:0] fdat_cnt_q, fdat_cnt_d;
  logic          fclk_prev_q;
  logic          clk_fall;

  frame_st_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          busy;
  logic          expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      fclk_q      <= 1'b1;
      fdat_q      <= 1'b1;
      fclk_cnt_q  <= '0;
      fdat_cnt_q  <= '0;
      fclk_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      clk_s1_q    <= ps2_clk_i;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data_i;
      dat_s2_q    <= dat_s1_q;
      fclk_q      <= fclk_d;
      fdat_q      <= fdat_d;
      fclk_cnt_q  <= fclk_cnt_d;
      fdat_cnt_q  <= fdat_cnt_d;
      fclk_prev_q <= fclk_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // A line only flips after FILT_LEN samples in a row disagree.
  always_comb begin
    fclk_d     = fclk_q;
    fclk_cnt_d = '0;
    if (clk_s2_q != fclk_q) begin
      if (fclk_cnt_q == CW'(FILT_LEN - 1))
        fclk_d = clk_s2_q;
      else
        fclk_cnt_d = fclk_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fdat_d     = fdat_q;
    fdat_cnt_d = '0;
    if (dat_s2_q != fdat_q) begin
      if (fdat_cnt_q == CW'(FILT_LEN - 1))
        fdat_d = dat_s2_q;
      else
        fdat_cnt_d = fdat_cnt_q + 1'b1;
    end
  end

  assign clk_fall = fclk_prev_q & ~fclk_q;
  assign busy     = (state_q != ST_IDLE) | pkt_busy;

  always_comb begin
    to_cnt_d = to_cnt_q;
    expire   = 1'b0;
    if (clk_fall || !busy) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      to_cnt_d = '0;
      expire   = 1'b1;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fdat_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {fdat_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7)
            state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = fdat_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (fdat_q && odd_ok(shift_q, par_q))
            byte_valid = 1'b1;
          else
            frame_err = 1'b1;
        end
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
    end
  end

  assign byte_data = shift_q;
  assign frame_to  = expire;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: assembles 3-byte movement packets into
// the 25-bit {toggle, dy, dx, status} word.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input logic            clk,
  input logic            reset_n,
  ps2_mouse_rx_if.slave  bus
);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;
  logic        frame_to;
  logic        sync_err;

  logic [1:0]  idx_q, idx_d;
  logic [7:0]  stat_q, stat_d;
  logic [7:0]  dx_q, dx_d;
  logic [24:0] mouse_q, mouse_d;
  logic        err_q, err_d;

  ps2_rx_byte #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_i  (bus.ps2_clk_i),
    .ps2_data_i (bus.ps2_data_i),
    .pkt_busy   (idx_q != 2'd0),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .frame_to   (frame_to)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      stat_q  <= '0;
      dx_q    <= '0;
      mouse_q <= '0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      stat_q  <= stat_d;
      dx_q    <= dx_d;
      mouse_q <= mouse_d;
      err_q   <= err_d;
    end
  end

  // Timeout, bad frame and good byte never coincide: an edge
  // cancels the timeout, and a stop edge is either good or bad.
  always_comb begin
    idx_d    = idx_q;
    stat_d   = stat_q;
    dx_d     = dx_q;
    mouse_d  = mouse_q;
    sync_err = 1'b0;
    unique case (1'b1)
      frame_to:  idx_d = '0;
      frame_err: idx_d = '0;
      byte_valid: begin
        unique case (idx_q)
          2'd0: begin
            if (byte_data[SYNC]) begin
              stat_d = byte_data;
              idx_d  = 2'd1;
            end else begin
              sync_err = 1'b1;
            end
          end
          2'd1: begin
            dx_d  = byte_data;
            idx_d = 2'd2;
          end
          2'd2: begin
            idx_d = 2'd0;
            mouse_d[PS2M_TOGGLE]    = ~mouse_q[PS2M_TOGGLE];
            mouse_d[PS2M_DY +: 8]   = byte_data;
            mouse_d[PS2M_DX +: 8]   = dx_q;
            mouse_d[PS2M_STAT +: 8] = stat_q;
          end
          default: idx_d = '0;
        endcase
      end
      default: ;
    endcase
  end

  assign err_d = frame_to | frame_err | sync_err;

  assign bus.ps2_mouse = mouse_q;
  assign bus.rx_err    = err_q;

endmodule
